// File: rtl/cpu_defs.sv
// rtl/cpu_defs.sv - shared CPU definitions: divider state encoding and widths
//
// Purpose: common constants and types used by the DIV/DIVU datapath.
//   DATA_W      operand/result width
//   DIV_ITERS   restoring-division iterations (one quotient bit each)
//   div_state_t divider FSM state encoding
package cpu_defs;

    localparam int DATA_W    = 32;
    localparam int DIV_ITERS = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_CALC = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring shift-subtract division step
//
// Purpose: purely combinational single iteration of restoring division.
// Ports:
//   rem       in   partial remainder
//   qsr       in   quotient shift register (dividend bits shift out of the MSB)
//   dvs       in   divisor magnitude
//   rem_next  out  partial remainder after this step
//   qsr_next  out  quotient shift register after this step
module div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] qsr,
    input  logic [W-1:0] dvs,
    output logic [W-1:0] rem_next,
    output logic [W-1:0] qsr_next
);

    // 33-bit trial: the shifted-in partial remainder can reach 2*dvs-1,
    // so the extra bit is needed; trial[W] set means the subtraction borrowed.
    logic [W:0] trial;

    assign trial = {rem, qsr[W-1]} - {1'b0, dvs};

    always_comb begin
        rem_next = {rem[W-2:0], qsr[W-1]};
        qsr_next = {qsr[W-2:0], 1'b0};
        if (!trial[W]) begin
            rem_next = trial[W-1:0];
            qsr_next = {qsr[W-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative 32-bit signed/unsigned divider for DIV/DIVU
//
// Purpose: restoring division, one quotient bit per falling clock edge,
// signed operands handled by magnitude with a final sign fix-up.
// Ports:
//   clk        in   clock; all state changes on the falling edge
//   rst        in   asynchronous active-high reset
//   start      in   request a division (sampled only in IDLE)
//   is_signed  in   1 = DIV (two's complement), 0 = DIVU
//   dividend   in   dividend, latched with start
//   divisor    in   divisor, latched with start
//   q          out  registered quotient (feeds LO)
//   r          out  registered remainder (feeds HI)
//   busy       out  high from the start cycle through the last CALC cycle (stalls PC)
//   done       out  one-cycle completion pulse (HI/LO enable)
module div_unit
    import cpu_defs::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done
);

    localparam int                CNT_W    = $clog2(DIV_ITERS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DIV_ITERS - 1);

    div_state_t       state;
    div_state_t       state_next;
    logic [WIDTH-1:0] rem;
    logic [WIDTH-1:0] qsr;
    logic [WIDTH-1:0] dvs;
    logic [CNT_W-1:0] count;
    logic             q_neg;
    logic             r_neg;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] qsr_nx;

    function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? negate(x) : x;
    endfunction

    div_step #(
        .W(WIDTH)
    ) u_step (
        .rem      (rem),
        .qsr      (qsr),
        .dvs      (dvs),
        .rem_next (rem_nx),
        .qsr_next (qsr_nx)
    );

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state <= DIV_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            DIV_IDLE: if (start) state_next = DIV_CALC;
            DIV_CALC: if (count == LAST_CNT) state_next = DIV_DONE;
            DIV_DONE: state_next = DIV_IDLE;
            default:  state_next = DIV_IDLE;
        endcase
    end

    // busy covers the start cycle itself so the PC never advances past the
    // DIV before the result lands; rst masks it because the state register
    // clears asynchronously anyway.
    assign busy = ~rst & (((state == DIV_IDLE) & start) | (state == DIV_CALC));
    assign done = (state == DIV_DONE);

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            rem   <= '0;
            qsr   <= '0;
            dvs   <= '0;
            count <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
            q     <= '0;
            r     <= '0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start) begin
                        rem   <= '0;
                        qsr   <= is_signed ? magnitude(dividend) : dividend;
                        dvs   <= is_signed ? magnitude(divisor) : divisor;
                        count <= '0;
                        q_neg <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        r_neg <= is_signed & dividend[WIDTH-1];
                    end
                end
                DIV_CALC: begin
                    rem   <= rem_nx;
                    qsr   <= qsr_nx;
                    count <= count + CNT_W'(1);
                    // Final iteration publishes the sign-corrected result
                    // directly from the step outputs.
                    if (count == LAST_CNT) begin
                        q <= q_neg ? negate(qsr_nx) : qsr_nx;
                        r <= r_neg ? negate(rem_nx) : rem_nx;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - self-checking testbench for div_unit
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    int          m_phase = 0;
    logic [31:0] m_q     = '0;
    logic [31:0] m_r     = '0;
    logic [31:0] m_pq    = '0;
    logic [31:0] m_pr    = '0;

    div_unit #(.WIDTH(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .dividend  (dividend),
        .divisor   (divisor),
        .q         (q),
        .r         (r),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void exp_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] eq, output logic [31:0] er);
        logic [31:0] ma, mb, mq, mr;
        ma = (s && a[31]) ? 32'd0 - a : a;
        mb = (s && b[31]) ? 32'd0 - b : b;
        if (mb == 32'd0) begin
            mq = 32'hFFFF_FFFF;
            mr = ma;
        end else begin
            mq = ma / mb;
            mr = ma % mb;
        end
        eq = (s && (a[31] ^ b[31])) ? 32'd0 - mq : mq;
        er = (s && a[31]) ? 32'd0 - mr : mr;
    endfunction

    // Cycle-level model: phase 0 idle, 1..32 computing, 33 result ready.
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0;
            m_q     = '0;
            m_r     = '0;
        end else begin
            if (m_phase == 0) begin
                if (start) begin
                    exp_div(is_signed, dividend, divisor, m_pq, m_pr);
                    m_phase = 1;
                end
            end else if (m_phase == 32) begin
                m_phase = 33;
                m_q     = m_pq;
                m_r     = m_pr;
            end else if (m_phase == 33) begin
                m_phase = 0;
            end else begin
                m_phase = m_phase + 1;
            end
        end
    end

    always @(posedge clk) begin
        logic exp_busy;
        exp_busy = !rst && ((m_phase == 0 && start) || (m_phase >= 1 && m_phase <= 32));
        chk("busy", 32'(busy), 32'(exp_busy));
        chk("done", 32'(done), 32'(m_phase == 33));
        chk("q", q, m_q);
        chk("r", r, m_r);
    end

    // Issue one division and wait (bounded) for its done pulse.
    task automatic do_div(input bit s, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] gq, output logic [31:0] gr, output int bcnt);
        bit got;
        got  = 0;
        bcnt = 0;
        gq   = '0;
        gr   = '0;
        @(negedge clk);
        #1;
        start     = 1'b1;
        is_signed = s;
        dividend  = a;
        divisor   = b;
        for (int i = 0; i < 45 && !got; i++) begin
            @(posedge clk);
            if (busy) bcnt++;
            if (done) begin
                got = 1;
                gq  = q;
                gr  = r;
            end
            if (i == 0) begin
                @(negedge clk);
                #1;
                start    = 1'b0;
                dividend = $urandom;
                divisor  = $urandom;
            end
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        logic [31:0] gq, gr, a, b;
        int          bc, ndone;
        bit          s;

        rst       = 1'b1;
        start     = 1'b0;
        is_signed = 1'b0;
        dividend  = '0;
        divisor   = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_q", q, 32'd0);
        chk("rst_r", r, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        do_div(1'b0, 32'd100, 32'd7, gq, gr, bc);
        chk("u100_7_q", gq, 32'd14);
        chk("u100_7_r", gr, 32'd2);
        chk("busy_len", 32'(bc), 32'd33);

        do_div(1'b1, 32'hFFFF_FF9C, 32'd7, gq, gr, bc);
        chk("s-100_7_q", gq, 32'hFFFF_FFF2);
        chk("s-100_7_r", gr, 32'hFFFF_FFFE);

        do_div(1'b0, 32'h1234_5678, 32'd0, gq, gr, bc);
        chk("udz_q", gq, 32'hFFFF_FFFF);
        chk("udz_r", gr, 32'h1234_5678);

        do_div(1'b1, 32'hFFFF_FFF6, 32'd0, gq, gr, bc);
        chk("sdz_q", gq, 32'h0000_0001);
        chk("sdz_r", gr, 32'hFFFF_FFF6);

        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, gq, gr, bc);
        chk("ovf_q", gq, 32'h8000_0000);
        chk("ovf_r", gr, 32'd0);
        // back-to-back: do_div returns in the DONE cycle, so start lands in the first IDLE cycle
        do_div(1'b0, 32'hFFFF_FFFF, 32'h10, gq, gr, bc);
        chk("b2b_q", gq, 32'h0FFF_FFFF);
        chk("b2b_r", gr, 32'hF);
        chk("b2b_busy_len", 32'(bc), 32'd33);

        // start held high with operands churning during CALC
        @(negedge clk);
        #1;
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd1000;
        divisor   = 32'd7;
        ndone     = 0;
        gq        = '0;
        gr        = '0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (done) begin
                ndone++;
                gq = q;
                gr = r;
            end
            @(negedge clk);
            #1;
            dividend = $urandom;
            divisor  = $urandom;
            if (ndone != 0) start = 1'b0;
        end
        chk("hold_ndone", 32'(ndone), 32'd1);
        chk("hold_q", gq, 32'd142);
        chk("hold_r", gr, 32'd6);

        // reset in the middle of a division
        @(negedge clk);
        #1;
        start    = 1'b1;
        dividend = 32'h0001_2345;
        divisor  = 32'h11;
        @(negedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_q", q, 32'd0);
        chk("midrst_r", r, 32'd0);
        @(negedge clk);
        #1;
        rst   = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            if (done) ndone++;
        end
        chk("midrst_ndone", 32'(ndone), 32'd0);

        do_div(1'b0, 32'd9, 32'd3, gq, gr, bc);
        chk("after_rst_q", gq, 32'd3);
        chk("after_rst_r", gr, 32'd0);

        // randomized divisions, checked every cycle by the model
        for (int n = 0; n < 150; n++) begin
            s = 1'($urandom_range(0, 1));
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = 32'($urandom_range(1, 20));
                3:       b = 32'd0 - 32'($urandom_range(1, 20));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            if ($urandom_range(0, 9) == 0) a = 32'h8000_0000;
            do_div(s, a, b, gq, gr, bc);
            chk("rnd_busy_len", 32'(bc), 32'd33);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative 32-bit integer divider for the single-cycle CPU's DIV/DIVU path. It sits directly upstream of the HI/LO storage registers: `done` drives their `ena`, `r` feeds HI's `data_in` and `q` feeds LO's `data_in`. While a division runs, `busy` holds the PC register (PC `ena` = ~`busy`). It runs a restoring shift-subtract algorithm, one quotient bit per clock, with signed handling by magnitude and sign fix-up.

## Interface
- `WIDTH`, 32, operand/result width (only 32 is verified).
- `clk`  in  1  clock; all state changes on the falling edge, the same edge the CPU registers use.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request a division; sampled only in IDLE.
- `is_signed`  in  1  1 = DIV (two's complement), 0 = DIVU; latched with `start`.
- `dividend`  in  32  latched with `start`.
- `divisor`  in  32  latched with `start`.
- `q`  out  32  quotient (registered).
- `r`  out  32  remainder (registered).
- `busy`  out  1  combinational: (state==IDLE && `start`) || state==CALC; forced 0 while `rst`.
- `done`  out  1  combinational: state==DONE; one-cycle pulse.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `start`=0 -> stay.
  - `start`=1 -> latch operands; remainder register = 0; quotient shift register = |dividend| (or dividend if unsigned); divisor register = |divisor|; count = 0; record quotient sign = dividend[31]^divisor[31] and remainder sign = dividend[31] (signed only); go to CALC.
- CALC, per edge:
  - Form 33-bit trial {rem[31:0], qsr[31]} − {1'b0, dvs}.
  - Non-negative -> rem = trial[31:0], shift 1 into qsr.
  - Negative -> rem = {rem[30:0], qsr[31]}, shift 0 into qsr.
  - count++; at count==31 the edge also applies sign fix-up, writes `q`/`r`, and moves to DONE.
- Sign fix-up (signed only): negate quotient if quotient sign=1; negate remainder if remainder sign=1. Remainder takes the sign of the dividend.
- DONE: `start` ignored; next edge -> IDLE.
- `q`/`r` hold their value until the next completion or reset.
- `start` and operand changes during CALC/DONE are ignored; operands are never re-sampled.
- Divide by zero (falls out of the algorithm, no special path):
  - Unsigned: q=0xFFFFFFFF, r=dividend.
  - Signed: magnitude result q=0xFFFFFFFF, r=|dividend|, then fix-up.
    - Quotient sign = dividend[31]^0 = dividend[31]: negative dividend gives q=0x00000001; non-negative dividend gives q=0xFFFFFFFF.
    - Remainder negated if dividend negative, so r=dividend in both cases.
- Overflow 0x80000000 / 0xFFFFFFFF signed: q=0x80000000, r=0; no trap.

## Timing
- Reset values: state=IDLE, `q`=0, `r`=0, `busy`=0, `done`=0; count and internal registers = 0.
- Start edge E0. Iterations on E1..E32. DONE during the cycle after E32. Return to IDLE on E33.
- `busy` is high for 33 cycles: the `start` cycle plus 32 CALC cycles.
- `done` is high for exactly 1 cycle, immediately after `busy` falls.
- HI/LO and PC all sample at E33: HI/LO load the result and PC advances.
- Back-to-back: `start` is accepted again in the first IDLE cycle after DONE.
- Reset mid-operation: immediate return to IDLE; outputs go to 0; no `done`; the partial result is discarded.

## Structure
- Shared package (`cpu_defs`): state encoding `DIV_IDLE`/`DIV_CALC`/`DIV_DONE` (2-bit), `DIV_ITERS`=32, `DATA_W`=32.
- One sub-module is natural: `div_step`, purely combinational. Inputs: rem, qsr, dvs. Outputs: next rem, next qsr. Instantiated once in `div_unit`.
- Target size: 150–250 lines RTL.

## Test plan
- Unsigned 100/7 (`is_signed`=0) -> `busy` high 33 cycles, then `done` 1 cycle with q=14, r=2.
- Signed −100/7 (0xFFFFFF9C / 0x00000007) -> q=0xFFFFFFF2 (−14), r=0xFFFFFFFE (−2).
- Divide by zero:
  - Unsigned 0x12345678/0 -> q=0xFFFFFFFF, r=0x12345678.
  - Signed 0xFFFFFFF6/0 -> q=0x00000001, r=0xFFFFFFF6.
- Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
  - Then, on the next `start`, unsigned 0xFFFFFFFF/0x10 issued back-to-back in the first IDLE cycle -> q=0x0FFFFFFF, r=0xF.
- Robustness, in one run:
  - Hold `start`=1 and toggle operands during CALC -> exactly one `done`, result from the E0 operands.
  - Then start a new division and assert `rst` at E10 -> `busy`, `q`, `r` go 0 immediately and no `done` is seen.
  - A fresh 9/3 then gives q=3, r=0.
